// File: rtl/raster_tracker_if.sv
// rtl/raster_tracker_if.sv - pixel stream bus: upstream beat in, coordinate-tagged beat out
interface raster_tracker_if #(
    parameter int WIDTH_P = 8,
    parameter int H_RES_P = 640,
    parameter int V_RES_P = 480
);
    localparam int XW = (H_RES_P > 1) ? $clog2(H_RES_P) : 1;
    localparam int YW = (V_RES_P > 1) ? $clog2(V_RES_P) : 1;

    logic               clear_i;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] data_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH_P-1:0] data_o;
    logic [XW-1:0]      x_o;
    logic [YW-1:0]      y_o;
    logic               sof_o;
    logic               eol_o;
    logic               eof_o;

    modport master (
        output clear_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, x_o, y_o, sof_o, eol_o, eof_o
    );

    modport slave (
        input  clear_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, x_o, y_o, sof_o, eol_o, eof_o
    );
endinterface

// File: rtl/raster_tracker.sv
// rtl/raster_tracker.sv - elastic output register that tags each pixel with its raster position
module raster_tracker #(
    parameter int WIDTH_P = 8,
    parameter int H_RES_P = 640,
    parameter int V_RES_P = 480
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    raster_tracker_if.slave   bus
);
    localparam int XW = (H_RES_P > 1) ? $clog2(H_RES_P) : 1;
    localparam int YW = (V_RES_P > 1) ? $clog2(V_RES_P) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES_P - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES_P - 1);

    logic [XW-1:0]      xcnt_q, xcnt_d;
    logic [YW-1:0]      ycnt_q, ycnt_d;
    logic               valid_q, valid_d;
    logic [WIDTH_P-1:0] data_q, data_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;
    logic               eof_q, eof_d;

    logic          in_hs;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          x_at_last;
    logic          y_at_last;

    assign bus.ready_o = ~valid_q | bus.ready_i;
    assign in_hs       = bus.valid_i & bus.ready_o;

    // clear overrides the running count for the beat accepted in the same cycle
    assign cur_x     = bus.clear_i ? '0 : xcnt_q;
    assign cur_y     = bus.clear_i ? '0 : ycnt_q;
    assign x_at_last = (cur_x == X_LAST);
    assign y_at_last = (cur_y == Y_LAST);

    always_comb begin
        xcnt_d  = xcnt_q;
        ycnt_d  = ycnt_q;
        valid_d = valid_q & ~bus.ready_i;
        data_d  = data_q;
        x_d     = x_q;
        y_d     = y_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        if (in_hs) begin
            valid_d = 1'b1;
            data_d  = bus.data_i;
            x_d     = cur_x;
            y_d     = cur_y;
            sof_d   = (cur_x == '0) && (cur_y == '0);
            eol_d   = x_at_last;
            eof_d   = x_at_last & y_at_last;
            xcnt_d  = x_at_last ? '0 : cur_x + XW'(1);
            if (x_at_last) begin
                ycnt_d = y_at_last ? '0 : cur_y + YW'(1);
            end else begin
                ycnt_d = cur_y;
            end
        end else if (bus.clear_i) begin
            xcnt_d = '0;
            ycnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            xcnt_q  <= '0;
            ycnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            xcnt_q  <= xcnt_d;
            ycnt_q  <= ycnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.x_o     = x_q;
    assign bus.y_o     = y_q;
    assign bus.sof_o   = sof_q;
    assign bus.eol_o   = eol_q;
    assign bus.eof_o   = eof_q;
endmodule

// File: tb/tb_raster_tracker.sv
// tb/tb_raster_tracker.sv - two instances (4x3 and 5x2) driven in lockstep against a scoreboard model
module tb_raster_tracker;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       v_s = 1'b0, r_s = 1'b0, c_s = 1'b0;
    logic [7:0] d_s = 8'h00;

    raster_tracker_if #(.WIDTH_P(8), .H_RES_P(4), .V_RES_P(3)) if_a ();
    raster_tracker_if #(.WIDTH_P(8), .H_RES_P(5), .V_RES_P(2)) if_b ();

    assign if_a.valid_i = v_s;
    assign if_a.ready_i = r_s;
    assign if_a.clear_i = c_s;
    assign if_a.data_i  = d_s;
    assign if_b.valid_i = v_s;
    assign if_b.ready_i = r_s;
    assign if_b.clear_i = c_s;
    assign if_b.data_i  = d_s;

    raster_tracker #(.WIDTH_P(8), .H_RES_P(4), .V_RES_P(3)) dut_a (.clk_i(clk), .rstn_i(rstn), .bus(if_a));
    raster_tracker #(.WIDTH_P(8), .H_RES_P(5), .V_RES_P(2)) dut_b (.clk_i(clk), .rstn_i(rstn), .bus(if_b));

    typedef struct {
        logic [7:0] d;
        int x0, y0; bit s0, e0, f0;
        int x1, y1; bit s1, e1, f1;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        int x, y; bit sof, eol, eof;
    } vec_t;

    exp_t q[$];
    int   total = 0, bad = 0, accepted = 0;
    int   mx0 = 0, my0 = 0, mx1 = 0, my1 = 0;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mx0 = 0; my0 = 0; mx1 = 0; my1 = 0;
    endtask

    task automatic do_cycle(input bit v, input bit r, input bit c, input logic [7:0] d);
        bit   exp_rdy, hs_in, hs_out;
        exp_t e;
        int   cx0, cy0, cx1, cy1;
        @(negedge clk);
        v_s = v; r_s = r; c_s = c; d_s = d;
        #1;
        exp_rdy = (q.size() == 0) || r;
        chk("ready_o", {31'd0, if_a.ready_o}, {31'd0, exp_rdy});
        chk("valid_a", {31'd0, if_a.valid_o}, {31'd0, q.size() != 0});
        chk("valid_b", {31'd0, if_b.valid_o}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("data_a", {24'd0, if_a.data_o}, {24'd0, q[0].d});
            chk("x_a", {30'd0, if_a.x_o}, q[0].x0);
            chk("y_a", {30'd0, if_a.y_o}, q[0].y0);
            chk("flags_a", {29'd0, if_a.sof_o, if_a.eol_o, if_a.eof_o}, {29'd0, q[0].s0, q[0].e0, q[0].f0});
            chk("data_b", {24'd0, if_b.data_o}, {24'd0, q[0].d});
            chk("x_b", {29'd0, if_b.x_o}, q[0].x1);
            chk("y_b", {31'd0, if_b.y_o}, q[0].y1);
            chk("flags_b", {29'd0, if_b.sof_o, if_b.eol_o, if_b.eof_o}, {29'd0, q[0].s1, q[0].e1, q[0].f1});
            if (if_b.x_o > 3'd4) chk("x_b_range", {29'd0, if_b.x_o}, 4);
        end
        hs_in  = v && exp_rdy;
        hs_out = (q.size() != 0) && r;
        if (hs_out) void'(q.pop_front());
        if (hs_in) begin
            cx0 = c ? 0 : mx0; cy0 = c ? 0 : my0;
            cx1 = c ? 0 : mx1; cy1 = c ? 0 : my1;
            e.d  = d;
            e.x0 = cx0; e.y0 = cy0; e.s0 = (cx0 == 0 && cy0 == 0);
            e.e0 = (cx0 == 3); e.f0 = (cx0 == 3 && cy0 == 2);
            e.x1 = cx1; e.y1 = cy1; e.s1 = (cx1 == 0 && cy1 == 0);
            e.e1 = (cx1 == 4); e.f1 = (cx1 == 4 && cy1 == 1);
            q.push_back(e);
            mx0 = (cx0 + 1) % 4; my0 = (cx0 == 3) ? (cy0 + 1) % 3 : cy0;
            mx1 = (cx1 + 1) % 5; my1 = (cx1 == 4) ? (cy1 + 1) % 2 : cy1;
            accepted++;
        end else if (c) begin
            mx0 = 0; my0 = 0; mx1 = 0; my1 = 0;
        end
        @(posedge clk);
    endtask

    initial begin
        int budget;
        tbl[0]  = '{8'd0,  0, 0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'd1,  1, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'd2,  2, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'd3,  3, 0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{8'd4,  0, 1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'd5,  1, 1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'd6,  2, 1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'd7,  3, 1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{8'd8,  0, 2, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8'd9,  1, 2, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{8'd10, 2, 2, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{8'd11, 3, 2, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{8'd12, 0, 0, 1'b1, 1'b0, 1'b0};

        // reset state
        #12;
        chk("rst_valid", {31'd0, if_a.valid_o}, 0);
        chk("rst_ready", {31'd0, if_a.ready_o}, 1);
        chk("rst_out_a", {if_a.data_o, 6'd0, if_a.x_o, if_a.y_o, if_a.sof_o, if_a.eol_o, if_a.eof_o}, 0);
        chk("rst_out_b", {if_b.data_o, 5'd0, if_b.x_o, if_b.y_o, if_b.sof_o, if_b.eol_o, if_b.eof_o}, 0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();

        // continuous stream, table-checked on the 4x3 instance and wrap-checked on the 5x2 instance
        for (int i = 0; i < 13; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, tbl[i].d);
            #1;
            chk("tbl_x", {30'd0, if_a.x_o}, tbl[i].x);
            chk("tbl_y", {30'd0, if_a.y_o}, tbl[i].y);
            chk("tbl_flags", {29'd0, if_a.sof_o, if_a.eol_o, if_a.eof_o}, {29'd0, tbl[i].sof, tbl[i].eol, tbl[i].eof});
            chk("tbl_b_x", {29'd0, if_b.x_o}, i % 5);
            chk("tbl_b_y", {31'd0, if_b.y_o}, (i / 5) % 2);
        end
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // clear without handshake, 6 beats, then clear coinciding with a handshake
        do_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
        do_cycle(1'b1, 1'b1, 1'b1, 8'h40);
        do_cycle(1'b1, 1'b1, 1'b0, 8'h41);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // backpressure: fill, hold for 5 cycles, release
        do_cycle(1'b1, 1'b0, 1'b0, 8'h50);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        do_cycle(1'b1, 1'b1, 1'b0, 8'h70);
        do_cycle(1'b1, 1'b1, 1'b0, 8'h71);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // random valid/ready over three 4x3 frames
        do_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        accepted = 0;
        budget = 0;
        while (accepted < 36 && budget < 2000) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            budget++;
        end
        if (accepted < 36) chk("rand_budget", accepted, 36);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("rand_drained", q.size(), 0);

        // async reset mid-line with the 4x3 counters at (2,1)
        do_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
        v_s = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_valid_a", {31'd0, if_a.valid_o}, 0);
        chk("arst_valid_b", {31'd0, if_b.valid_o}, 0);
        chk("arst_out_a", {if_a.data_o, 6'd0, if_a.x_o, if_a.y_o, if_a.sof_o, if_a.eol_o, if_a.eof_o}, 0);
        chk("arst_ready", {31'd0, if_a.ready_o}, 1);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        model_reset();
        do_cycle(1'b1, 1'b1, 1'b0, 8'h90);
        do_cycle(1'b1, 1'b1, 1'b0, 8'h91);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/raster_tracker.md
RASTER_TRACKER -- requirements
Module: raster_tracker

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, pixel data width in bits.
REQ-002 SHALL have parameter H_RES_P, default 640, pixels per line; legal range 2 or more.
REQ-003 SHALL have parameter V_RES_P, default 480, lines per frame; legal range 2 or more.
REQ-004 SHALL have localparams XW = $clog2(H_RES_P) and YW = $clog2(V_RES_P), each with a minimum of 1.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port clear_i, input, 1, synchronous frame restart.
REQ-008 SHALL have port valid_i, input, 1, upstream beat valid.
REQ-009 SHALL have port ready_o, output, 1, upstream may transfer.
REQ-010 SHALL have port data_i, input, WIDTH_P, upstream pixel.
REQ-011 SHALL have port valid_o, output, 1, downstream beat valid.
REQ-012 SHALL have port ready_i, input, 1, downstream accepts.
REQ-013 SHALL have port data_o, output, WIDTH_P, registered pixel.
REQ-014 SHALL have port x_o, output, XW, column of the beat on data_o.
REQ-015 SHALL have port y_o, output, YW, row of the beat on data_o.
REQ-016 SHALL have port sof_o, output, 1, beat is (0,0).
REQ-017 SHALL have port eol_o, output, 1, beat has x = H_RES_P-1.
REQ-018 SHALL have port eof_o, output, 1, beat is (H_RES_P-1, V_RES_P-1).

Function
REQ-019 SHALL define an input handshake as valid_i & ready_o, and an output handshake as valid_o & ready_i.
REQ-020 SHALL implement a single-entry elastic output register with ready_o = ~valid_o | ready_i, giving full throughput of one beat per cycle.
REQ-021 SHALL load data_i, the current column counter, the current row counter and the derived flags into the output register on each input handshake; latency input to output is 1 cycle.
REQ-022 SHALL hold data_o, x_o, y_o, sof_o, eol_o and eof_o stable while valid_o=1 and ready_i=0.
REQ-023 SHALL clear valid_o on an output handshake with no input handshake in the same cycle.
REQ-024 SHALL, when input and output handshakes coincide, keep valid_o=1 and load the new beat.
REQ-025 SHALL advance the internal column counter by 1 per input handshake only, and wrap it from H_RES_P-1 to 0.
REQ-026 SHALL advance the internal row counter only on a column wrap, and wrap it from V_RES_P-1 to 0; this wrap starts the next frame with no idle cycle.
REQ-027 SHALL leave both counters unchanged in cycles with no input handshake, whatever valid_i, ready_i or data_i are doing.
REQ-028 SHALL, on clear_i=1 with no input handshake, set both counters to 0 and leave the output register untouched.
REQ-029 SHALL, on clear_i=1 coinciding with an input handshake, tag the accepted beat (0,0) with sof=1 and set the counters to (1,0); clear takes priority over the old count.
REQ-030 SHALL never let the counters hold a value at or above H_RES_P or V_RES_P, including for non-power-of-2 resolutions.
REQ-031 SHALL compute the flags from the pre-increment counter values.

Reset
REQ-032 SHALL, while rstn_i=0, asynchronously force valid_o=0, data_o=0, x_o=0, y_o=0, sof_o=0, eol_o=0, eof_o=0, and both internal counters to 0.
REQ-033 SHALL drive ready_o=1 during reset and on the first cycle after deassertion, because valid_o=0.
REQ-034 SHALL make reset asserted mid-frame discard the in-flight beat, and SHALL tag the first beat after release (0,0) with sof=1.

Verification
REQ-035 SHALL verify the continuous stream case: with H_RES_P=4, V_RES_P=3, valid_i=1 and ready_i=1, feed 12 beats; required response is (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2), with eol on x=3, eof only on beat 12, and beat 13 tagged (0,0) with sof=1.
REQ-036 SHALL verify backpressure: hold ready_i=0 for 5 cycles with the register full; required response is ready_o=0, outputs frozen, counters frozen; on release, no beat is lost or duplicated.
REQ-037 SHALL verify random valid_i/ready_i toggling over 3 frames: output coordinates match a reference scoreboard and the data order is preserved.
REQ-038 SHALL verify clear_i: after 6 beats, pulse clear_i together with a handshake; required response is that beat tagged (0,0) with sof=1, and the next beat tagged (1,0).
REQ-039 SHALL verify async reset: assert rstn_i mid-line at (2,1), away from a clock edge; required response is valid_o falling immediately, and the first post-reset beat tagged (0,0).
REQ-040 SHALL verify a non-power-of-2 resolution: with H_RES_P=5, x_o never exceeds 4 and wraps 4 to 0 with y incrementing.
